mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the unified instruction/data memory used by the multicycle processor. Port 0 is the CPU memory interface, driven from its FETCH/MEMREAD/MEMWRITE steps; port 1 is the program loader/debug port. The block serialises accesses from both ports onto one memory port with a ready handshake. It applies round-robin arbitration with an optional port-1 lock, and a watchdog that aborts accesses the memory never acknowledges.

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the two requester ports and the shared memory port
//               of mem_port_arbiter. The slave modport is the arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // requester 0 (CPU)
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_done;
  logic          m0_err;
  logic [DW-1:0] m0_rdata;
  // requester 1 (loader/debug)
  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_lock;
  logic          m1_gnt;
  logic          m1_done;
  logic          m1_err;
  logic [DW-1:0] m1_rdata;
  // shared memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  // arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_done, m1_err, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // requester/memory environment side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_done, m1_err, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port round-robin arbiter/sequencer onto a single memory
//               port with ready handshake, port-1 priority lock and an
//               access watchdog that aborts unacknowledged accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int             WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WDOG_MAX  = {WDW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q,      state_d;
  logic            owner_q,      owner_d;
  logic            last_owner_q, last_owner_d;
  logic            mem_en_q,     mem_en_d;
  logic            mem_we_q,     mem_we_d;
  logic [AW-1:0]   mem_addr_q,   mem_addr_d;
  logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [WDW-1:0]  wdog_q,       wdog_d;
  logic [DW-1:0]   m0_rdata_q,   m0_rdata_d;
  logic [DW-1:0]   m1_rdata_q,   m1_rdata_d;
  logic [1:0]      gnt_q,        gnt_d;
  logic [1:0]      done_q,       done_d;
  logic [1:0]      err_q,        err_d;
  logic            winner;

  // Winner selection: a lone request wins; on a tie the lock keeps port 1
  // only if it was the last owner, otherwise the other port gets its turn.
  always_comb begin
    winner = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      winner = (bus.m1_lock && last_owner_q) ? 1'b1 : ~last_owner_q;
    end else if (bus.m1_req) begin
      winner = 1'b1;
    end
  end

  // Sequencer next-state: grant, wait for ready or watchdog, report, return.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wdog_d       = wdog_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    done_d       = 2'b00;
    err_d        = 2'b00;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d      = BUSY;
          owner_d      = winner;
          last_owner_d = winner;
          mem_en_d     = 1'b1;
          mem_we_d     = winner ? bus.m1_we    : bus.m0_we;
          mem_addr_d   = winner ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_d  = winner ? bus.m1_wdata : bus.m0_wdata;
          wdog_d       = '0;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          state_d         = RESP;
          mem_en_d        = 1'b0;
          mem_we_d        = 1'b0;
          done_d[owner_q] = 1'b1;
          if (!mem_we_q) begin
            if (owner_q) m1_rdata_d = bus.mem_rdata;
            else         m0_rdata_d = bus.mem_rdata;
          end
        end else if (wdog_q == WDOG_LAST) begin
          // Memory never answered: abort, reads return zero.
          state_d         = RESP;
          mem_en_d        = 1'b0;
          mem_we_d        = 1'b0;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          if (!mem_we_q) begin
            if (owner_q) m1_rdata_d = '0;
            else         m0_rdata_d = '0;
          end
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    gnt_d = 2'b00;
    if (state_d != IDLE) begin
      gnt_d = owner_d ? 2'b10 : 2'b01;
    end
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wdog_q       <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wdog_q       <= wdog_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_done   = done_q[0];
  assign bus.m1_done   = done_q[1];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.m1_lock = 0; bus.mem_rdata = '0; bus.mem_ready = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
    chk("rst_done_err", {bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}, 0);
    chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);

    // single zero-wait CPU read
    bus.m0_req = 1; bus.m0_addr = 32'h10; bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_mem_en", bus.mem_en, 1);
    chk("rd_mem_addr", bus.mem_addr, 32'h10);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_m0_gnt", bus.m0_gnt, 1);
    @(negedge clk);
    chk("rd_m0_done", bus.m0_done, 1);
    chk("rd_m0_err", bus.m0_err, 0);
    chk("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_mem_en_off", bus.mem_en, 0);
    chk("rd_m1_quiet", {bus.m1_gnt, bus.m1_done, bus.m1_err, bus.m1_rdata}, 0);
    bus.m0_req = 0;
    @(negedge clk);
    chk("rd_done_pulse", bus.m0_done, 0);
    chk("rd_idle_gnt", bus.m0_gnt, 0);

    // fresh reset so the round robin starts from last_owner=1
    reset = 1;
    @(negedge clk);
    reset = 0;

    // contention, zero-wait: m0,m1,m0,m1 with a 3-cycle period
    bus.m0_req = 1; bus.m1_req = 1; bus.m1_addr = 32'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rdata = 32'hA000_0000 + i;
      chk($sformatf("cont%0d_m0_gnt", i), bus.m0_gnt, (i % 2) == 0);
      chk($sformatf("cont%0d_m1_gnt", i), bus.m1_gnt, (i % 2) == 1);
      chk($sformatf("cont%0d_addr", i), bus.mem_addr, (i % 2) ? 32'h44 : 32'h10);
      @(negedge clk);
      chk($sformatf("cont%0d_done", i), {bus.m1_done, bus.m0_done}, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("cont%0d_rdata", i), (i % 2) ? bus.m1_rdata : bus.m0_rdata, 32'hA000_0000 + i);
      @(negedge clk);
      chk($sformatf("cont%0d_idle", i), {bus.m1_gnt, bus.m0_gnt, bus.mem_en}, 0);
    end

    // lock: last owner is m1, so all three go to m1
    bus.m1_lock = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_rdata = 32'hB000_0000 + i;
      chk($sformatf("lock%0d_m1_gnt", i), {bus.m1_gnt, bus.m0_gnt}, 2'b10);
      @(negedge clk);
      chk($sformatf("lock%0d_done", i), {bus.m1_done, bus.m0_done}, 2'b10);
      @(negedge clk);
    end
    bus.m1_lock = 0;
    @(negedge clk);
    bus.mem_rdata = 32'hC0DE_0000;
    chk("unlock_m0_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
    @(negedge clk);
    chk("unlock_m0_rdata", bus.m0_rdata, 32'hC0DE_0000);
    chk("lock_m1_rdata", bus.m1_rdata, 32'hB000_0002);
    bus.m0_req = 0; bus.m1_req = 0;
    @(negedge clk);

    // m1 write with 3 wait states
    bus.mem_ready = 0; bus.mem_rdata = 32'hBAD0_BAD0;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wr%0d_cmd", i), {bus.mem_en, bus.mem_we, bus.m1_gnt}, 3'b111);
      chk($sformatf("wr%0d_addr", i), bus.mem_addr, 32'h20);
      chk($sformatf("wr%0d_wdata", i), bus.mem_wdata, 32'h55);
      chk($sformatf("wr%0d_nodone", i), bus.m1_done, 0);
      if (i == 3) bus.mem_ready = 1;
    end
    @(negedge clk);
    chk("wr_done", {bus.m1_done, bus.m1_err}, 2'b10);
    chk("wr_rdata_kept", bus.m1_rdata, 32'hB000_0002);
    chk("wr_resp_en_we", {bus.mem_en, bus.mem_we}, 0);
    bus.m1_req = 0; bus.m1_we = 0; bus.mem_ready = 0;
    @(negedge clk);
    chk("wr_done_pulse", bus.m1_done, 0);

    // timeout on an m0 read
    bus.m0_req = 1; bus.m0_addr = 32'h30; bus.mem_rdata = 32'hCAFE_F00D;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_en) cnt++;
      if (bus.m0_done) break;
    end
    chk("to_en_cycles", cnt, TIMEOUT);
    chk("to_done_err", {bus.m0_done, bus.m0_err}, 2'b11);
    chk("to_rdata_zero", bus.m0_rdata, 0);
    chk("to_m1_quiet", {bus.m1_done, bus.m1_err}, 0);
    bus.m0_req = 0;
    @(negedge clk);
    chk("to_err_pulse", {bus.m0_done, bus.m0_err}, 0);

    // asynchronous reset three cycles into a wait
    bus.m0_req = 1;
    repeat (3) @(negedge clk);
    chk("ar_busy", {bus.mem_en, bus.m0_gnt}, 2'b11);
    #2 reset = 1;
    #1;
    chk("ar_immediate", {bus.mem_en, bus.m0_gnt, bus.m0_done, bus.m0_err}, 0);
    bus.m0_req = 0;
    @(negedge clk);
    reset = 0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.m0_done || bus.m0_err || bus.mem_en) cnt++;
    end
    chk("ar_no_done", cnt, 0);
    bus.m0_req = 1; bus.m1_req = 1; bus.mem_ready = 1;
    @(negedge clk);
    chk("ar_fresh_m0_first", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
    @(negedge clk);
    chk("ar_fresh_done", bus.m0_done, 1);
    bus.m0_req = 0; bus.m1_req = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
